// File: rtl/bitwise_arbiter_pkg.sv
// Shared definitions for the bitwise arbiter: opcodes and FSM states.
package bitwise_arbiter_pkg;

    // Opcodes understood by the shared bitwise unit.
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NOTA = 2'b11;

    // Sequencer states: wait for a request, compute, present the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/bitwise_core.sv
// Shared combinational bitwise unit: AND / OR / XOR / NOT-A.
module bitwise_core
    import bitwise_arbiter_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] y
);

    // Select the operation; B is ignored for NOT-A.
    always_comb begin
        // NOTE: giving y a value before the case means no path leaves it
        // unassigned, so no latch can be inferred.
        y = a & b;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOTA: y = ~a;
            default: y = a & b;
        endcase
    end

endmodule

// File: rtl/bitwise_arbiter.sv
// Round-robin arbiter/sequencer sharing one bitwise unit between NUM_REQ
// requesters. One operation in flight at a time: IDLE -> EXEC -> RESP.
module bitwise_arbiter
    import bitwise_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int DATA_W  = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]      req_op,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy,
    output logic [7:0]                done_count
);

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_found;
    logic              accept;
    logic [ID_W-1:0]   ptr_next;

    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [1:0]        sel_op;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [1:0]        op_q;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] core_y;

    // Round-robin winner: lowest valid index at or above ptr, otherwise
    // the lowest valid index below ptr (the wrapped part of the search).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i < int'(ptr))) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i >= int'(ptr))) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
    end

    // Ready is offered only in IDLE and only to the winner, so it is one-hot or zero.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Route the winner's operands towards the operand registers.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = OP_AND;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_idx) begin
                sel_a  = req_a[i*DATA_W +: DATA_W];
                sel_b  = req_b[i*DATA_W +: DATA_W];
                sel_op = req_op[i*2 +: 2];
            end
        end
    end

    assign accept    = (state == IDLE) && grant_found;
    assign ptr_next  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    bitwise_core #(.DATA_W(DATA_W)) u_core (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (core_y)
    );

    // Sequencer: accept one request, compute it, hold the result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            // NOTE: the operand and result registers are few and small, so
            // they are reset too; outputs are then defined straight out of reset.
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_AND;
            id_q       <= '0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            done_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        op_q  <= sel_op;
                        id_q  <= grant_idx;
                        ptr   <= ptr_next;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data <= core_y;
                    rsp_id   <= id_q;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        done_count <= done_count + 8'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitwise_arbiter.sv
// Self-checking bench for bitwise_arbiter (NUM_REQ = 2, DATA_W = 4).
module tb_bitwise_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 4;
    localparam int ID_W    = 1;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*2-1:0]      req_op;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [ID_W-1:0]           rsp_id;
    logic                      busy;
    logic [7:0]                done_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: round-robin pointer and completed-response count.
    int rr_ptr = 0;
    int dc_exp = 0;

    bitwise_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         req;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [3:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"},  32'(req_ready),  0);
        check({tag, "_rsp_valid"},  32'(rsp_valid),  0);
        check({tag, "_rsp_data"},   32'(rsp_data),   0);
        check({tag, "_rsp_id"},     32'(rsp_id),     0);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_done_count"}, 32'(done_count), 0);
    endtask

    // Called at a negedge with the DUT in IDLE. Presents requests, follows
    // one operation to completion, returns at the negedge after the response.
    task automatic run_txn(input logic [1:0] mask, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op, input int stall,
                           output logic [ID_W-1:0] got_id, output logic [3:0] got_data);
        int w;
        logic [3:0] exp;
        w = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (rr_ptr + k) % NUM_REQ;
            if (w < 0 && mask[idx]) w = idx;
        end
        exp = model(a[w*DATA_W +: DATA_W], b[w*DATA_W +: DATA_W], op[w*2 +: 2]);

        req_valid = mask;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        rsp_ready = (stall == 0);
        #1;
        check("grant", 32'(req_ready), 32'(1 << w));
        check("idle_not_busy", 32'(busy), 0);

        @(negedge clk);
        check("exec_busy", 32'(busy), 1);
        check("exec_no_ready", 32'(req_ready), 0);
        check("exec_no_rsp", 32'(rsp_valid), 0);

        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 1);
        check("rsp_data", 32'(rsp_data), 32'(exp));
        check("rsp_id", 32'(rsp_id), 32'(w));
        got_id   = rsp_id;
        got_data = rsp_data;

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 1);
            check("stall_data", 32'(rsp_data), 32'(exp));
            check("stall_id", 32'(rsp_id), 32'(w));
            check("stall_busy", 32'(busy), 1);
            check("stall_no_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        req_valid = '0;

        @(negedge clk);
        dc_exp = (dc_exp + 1) % 256;
        rr_ptr = (w + 1) % NUM_REQ;
        check("done_rsp_low", 32'(rsp_valid), 0);
        check("done_count", 32'(done_count), 32'(dc_exp));
        check("done_idle", 32'(busy), 0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        rr_ptr = 0;
        dc_exp = 0;
    endtask

    initial begin
        vec_t            vecs[5];
        logic [ID_W-1:0] gid;
        logic [3:0]      gdata;
        logic [7:0]      ra, rb;
        logic [3:0]      rop;

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        rst       = 1'b1;
        #1;
        check_reset_vals("reset");
        do_reset();
        check_reset_vals("post_reset");

        // Directed operations on a single requester.
        vecs[0] = '{req: 0, a: 4'b1010, b: 4'b1100, op: 2'b00, exp: 4'b1000};
        vecs[1] = '{req: 1, a: 4'b1010, b: 4'b1100, op: 2'b01, exp: 4'b1110};
        vecs[2] = '{req: 1, a: 4'b1010, b: 4'b1100, op: 2'b10, exp: 4'b0110};
        vecs[3] = '{req: 1, a: 4'b1010, b: 4'b1100, op: 2'b11, exp: 4'b0101};
        vecs[4] = '{req: 0, a: 4'b0110, b: 4'b0011, op: 2'b10, exp: 4'b0101};
        for (int i = 0; i < 5; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 4'($urandom);
            ra[vecs[i].req*DATA_W +: DATA_W] = vecs[i].a;
            rb[vecs[i].req*DATA_W +: DATA_W] = vecs[i].b;
            rop[vecs[i].req*2 +: 2]          = vecs[i].op;
            run_txn(2'(1 << vecs[i].req), ra, rb, rop, 0, gid, gdata);
            check("vec_data", 32'(gdata), 32'(vecs[i].exp));
            check("vec_id", 32'(gid), 32'(vecs[i].req));
            if (i == 0) check("first_done_count", 32'(done_count), 1);
        end

        // Both requesters continuously valid: grants alternate 0,1,0,1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_txn(2'b11, 8'h5A, 8'h3C, 4'b0110, 0, gid, gdata);
            check("alt_order", 32'(gid), 32'(i % 2));
        end

        // Response back-pressure for 5 cycles while requester 1 waits; it is
        // then withdrawn before being accepted.
        do_reset();
        run_txn(2'b11, 8'h9A, 8'h4C, 4'b0100, 5, gid, gdata);
        check("stall_owner", 32'(gid), 0);
        check("stall_result", 32'(gdata), 32'(4'b1000));
        @(negedge clk);
        check("withdraw_idle", 32'(busy), 0);
        check("withdraw_no_rsp", 32'(rsp_valid), 0);

        // Reset while an operation is in EXEC: result discarded.
        req_valid = 2'b01;
        req_a     = 8'h0F;
        req_b     = 8'h00;
        req_op    = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        check("rst_exec_grant", 32'(req_ready), 1);
        @(negedge clk);
        check("rst_exec_busy", 32'(busy), 1);
        req_valid = '0;
        rst       = 1'b1;
        #1;
        check_reset_vals("rst_exec");
        @(negedge clk);
        rst    = 1'b0;
        rr_ptr = 0;
        dc_exp = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_exec_no_rsp", 32'(rsp_valid), 0);
            check("rst_exec_count", 32'(done_count), 0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            run_txn(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 4'($urandom),
                    $urandom_range(0, 3), gid, gdata);
        end

        // 256 back-to-back operations: done_count wraps to 0.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                run_txn(2'b01, 8'h00, 8'hFF, 4'b1111, 0, gid, gdata);
            end else begin
                run_txn(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 4'($urandom),
                        0, gid, gdata);
            end
        end
        check("wrap_count", 32'(done_count), 0);
        check("wrap_final_data", 32'(gdata), 32'(4'b1111));
        check("wrap_final_id", 32'(gid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
